// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode/register codes and fetch FSM state for the CPU front end
package cpu_pkg;
  localparam int ADDR_W = 5;
  localparam int INS_W  = 6;
  localparam int CNT_W  = 8;
  localparam logic [3:0] OPCODE_NOP = 4'h0;
  localparam logic [3:0] OPCODE_ADD = 4'h1;
  localparam logic [3:0] OPCODE_SUB = 4'h2;
  localparam logic [3:0] OPCODE_AND = 4'h3;
  localparam logic [3:0] OPCODE_OR  = 4'h4;
  localparam logic [3:0] OPCODE_XOR = 4'h5;
  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;
  typedef enum logic {RUN, HALT} fetch_state_t;
  function automatic logic [INS_W-1:0] mk_ins(input logic [3:0] op, input logic [1:0] rg);
    return {op, rg};
  endfunction
endpackage

// File: rtl/program_counter.sv
// program_counter: PC register with load/increment/hold and a one-cycle wrap pulse
module program_counter #(
  parameter int ADDR_W = 5,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_load_addr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_wrap
);
  logic [ADDR_W-1:0] r_pc;
  logic              r_wrap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_ADDR;
      r_wrap <= 1'b0;
    end else begin
      r_pc   <= i_load ? i_load_addr : i_inc ? r_pc + 1'b1 : r_pc;
      r_wrap <= !i_load && i_inc && (&r_pc);
    end
  end
  assign o_pc   = r_pc;
  assign o_wrap = r_wrap;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage owning the PC, instruction register, run/halt FSM and fetch counter
module instr_fetch_unit #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INS_W  = cpu_pkg::INS_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [INS_W-1:0]  ins_in,
  output logic [INS_W-1:0]  ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              pc_wrap,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_cnt
);
  import cpu_pkg::*;
  localparam logic [INS_W-1:0] NOP_INS = INS_W'({OPCODE_NOP, R0});
  fetch_state_t      r_state;
  logic [INS_W-1:0]  r_ir;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_active;
  logic              w_jump;
  logic              w_fetch;
  // a halt request pre-empts jump/fetch on the same edge
  assign w_active = (r_state == RUN) && !halt;
  assign w_jump   = w_active && jump_en;
  assign w_fetch  = w_active && !jump_en && !stall;
  program_counter #(.ADDR_W(ADDR_W), .RESET_ADDR(RESET_ADDR)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_jump),
    .i_inc      (w_fetch),
    .i_load_addr(jump_addr),
    .o_pc       (pc_addr),
    .o_wrap     (pc_wrap)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_ir    <= NOP_INS;
      r_ir_pc <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= halt ? HALT : (r_state == HALT && resume) ? RUN : r_state;
      if (w_jump) begin
        r_ir    <= NOP_INS;
        r_valid <= 1'b0;
      end else if (w_fetch) begin
        r_ir    <= ins_in;
        r_ir_pc <= pc_addr;
        r_valid <= 1'b1;
        r_cnt   <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
      end else if (!w_active) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign ir_out    = r_ir;
  assign ir_pc     = r_ir_pc;
  assign ir_valid  = r_valid;
  assign halted    = (r_state == HALT);
  assign fetch_cnt = r_cnt;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of the fetch stage against a behavioural model
module tb_instr_fetch_unit;
  import cpu_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       jump_en = 1'b0;
  logic       halt = 1'b0;
  logic       resume = 1'b0;
  logic [4:0] jump_addr = '0;
  logic [4:0] pc_addr;
  logic [4:0] ir_pc;
  logic [5:0] ins_in;
  logic [5:0] ir_out;
  logic       ir_valid;
  logic       pc_wrap;
  logic       halted;
  logic [7:0] fetch_cnt;
  logic [5:0] mem [32];
  int n_checks = 0;
  int n_fail = 0;
  int m_pc, m_ir, m_irpc, m_cnt;
  bit m_valid, m_wrap, m_halted;
  always #5 clk = ~clk;
  assign ins_in = mem[pc_addr];
  instr_fetch_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .jump_en  (jump_en),
    .jump_addr(jump_addr),
    .halt     (halt),
    .resume   (resume),
    .pc_addr  (pc_addr),
    .ins_in   (ins_in),
    .ir_out   (ir_out),
    .ir_pc    (ir_pc),
    .ir_valid (ir_valid),
    .pc_wrap  (pc_wrap),
    .halted   (halted),
    .fetch_cnt(fetch_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_irpc = 0; m_cnt = 0;
    m_valid = 0; m_wrap = 0; m_halted = 0;
  endtask
  task automatic model_edge(input bit s, input bit j, input int ja, input bit h, input bit r);
    m_wrap = 0;
    if (m_halted) begin
      if (!h && r) m_halted = 0;
    end else if (h) begin
      m_halted = 1;
      m_valid = 0;
    end else if (j) begin
      m_pc = ja;
      m_ir = 0;
      m_valid = 0;
    end else if (!s) begin
      m_ir = mem[m_pc];
      m_irpc = m_pc;
      m_valid = 1;
      m_wrap = (m_pc == 31);
      m_pc = (m_pc + 1) % 32;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
  endtask
  task automatic check_all();
    check("pc_addr", pc_addr, m_pc);
    check("ir_out", ir_out, m_ir);
    check("ir_pc", ir_pc, m_irpc);
    check("ir_valid", ir_valid, m_valid);
    check("pc_wrap", pc_wrap, m_wrap);
    check("halted", halted, m_halted);
    check("fetch_cnt", fetch_cnt, m_cnt);
  endtask
  task automatic cycle(input bit s, input bit j, input int ja, input bit h, input bit r);
    stall = s; jump_en = j; jump_addr = 5'(ja); halt = h; resume = r;
    @(posedge clk);
    model_edge(s, j, ja, h, r);
    @(negedge clk);
    check_all();
  endtask
  task automatic run(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    stall = 0; jump_en = 0; halt = 0; resume = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all();
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = mk_ins(OPCODE_NOP, R0);
    mem[0] = mk_ins(OPCODE_ADD, R1);
    mem[1] = mk_ins(OPCODE_SUB, R1);
    mem[2] = mk_ins(OPCODE_SUB, R1);
    mem[3] = mk_ins(OPCODE_ADD, R2);
    mem[4] = mk_ins(OPCODE_AND, R3);
    mem[5] = mk_ins(OPCODE_ADD, R3);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all();
    check("t1_reset_ir", ir_out, 6'h00);
    run(6);
    check("t1_pc", pc_addr, 6);
    check("t1_ir", ir_out, 6'h07);
    check("t1_cnt", fetch_cnt, 6);
    do_reset();
    run(3);
    repeat (3) cycle(1, 0, 0, 0, 0);
    check("t2_pc_held", pc_addr, 3);
    check("t2_ir_held", ir_out, 6'h09);
    check("t2_cnt_held", fetch_cnt, 3);
    run(1);
    check("t2_release_ir", ir_out, 6'h06);
    cycle(1, 1, 4, 0, 0);
    check("t3_pc", pc_addr, 4);
    check("t3_valid", ir_valid, 0);
    check("t3_bubble", ir_out, 6'h00);
    run(1);
    check("t3_ir", ir_out, 6'h0F);
    check("t3_ir_pc", ir_pc, 4);
    cycle(0, 1, 30, 0, 0);
    run(1);
    check("t4_no_wrap_31", pc_wrap, 0);
    run(1);
    check("t4_wrap", pc_wrap, 1);
    check("t4_pc0", pc_addr, 0);
    run(1);
    check("t4_wrap_1cyc", pc_wrap, 0);
    cycle(0, 1, 31, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("t4_jump0_wrap", pc_wrap, 0);
    cycle(0, 1, 2, 0, 0);
    cycle(0, 0, 0, 1, 0);
    check("t5_halted", halted, 1);
    cycle(0, 1, 9, 0, 0);
    check("t5_pc_held", pc_addr, 2);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("t5_resumed", halted, 0);
    run(1);
    check("t5_fetch_pc", ir_pc, 2);
    run(260);
    check("t6_sat", fetch_cnt, 255);
    cycle(0, 0, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_pc", pc_addr, 0);
    check("t6_rst_ir", ir_out, 0);
    check("t6_rst_valid", ir_valid, 0);
    check("t6_rst_halted", halted, 0);
    check("t6_rst_cnt", fetch_cnt, 0);
    model_reset();
    halt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 31)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
